// File: rtl/reg_read_stage.sv
// Register-read stage: drives regfile read ports, bypasses same-cycle
// writebacks over the read data, and holds up to two uops (head + skid)
// toward execute. iss_ready is registered so it has no path from ex_ready.
module reg_read_stage #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_WB    = 2,
    parameter int UOP_W     = 64,
    localparam int PW       = $clog2(NUM_PREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [PW-1:0]        iss_src1_preg,
    input  logic [PW-1:0]        iss_src2_preg,
    input  logic [UOP_W-1:0]     iss_uop,
    output logic [PW-1:0]        prf_src1_reg,
    output logic [PW-1:0]        prf_src2_reg,
    input  logic [31:0]          prf_src1_val,
    input  logic [31:0]          prf_src2_val,
    input  logic [NUM_WB-1:0]    wb_valid,
    input  logic [NUM_WB*PW-1:0] wb_preg,
    input  logic [NUM_WB*32-1:0] wb_data,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [UOP_W-1:0]     ex_uop,
    output logic [31:0]          ex_src1_val,
    output logic [31:0]          ex_src2_val
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state, state_next;
    logic               ready_q;
    logic               accept, drain;
    logic               load_h, load_s, move_s;
    logic [31:0]        op1, op2;
    logic [UOP_W-1:0]   h_uop, s_uop;
    logic [31:0]        h_v1, h_v2, s_v1, s_v2;

    assign prf_src1_reg = iss_src1_preg;
    assign prf_src2_reg = iss_src2_preg;

    assign iss_ready   = ready_q;
    assign ex_valid    = (state != EMPTY);
    assign ex_uop      = h_uop;
    assign ex_src1_val = h_v1;
    assign ex_src2_val = h_v2;

    assign accept = iss_valid & ready_q;
    assign drain  = ex_valid & ex_ready;

    // Operand select: later (higher-index) writeback ports override earlier ones
    always_comb begin
        op1 = prf_src1_val;
        op2 = prf_src2_val;
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            if (wb_valid[i] && (wb_preg[i*PW +: PW] == iss_src1_preg))
                op1 = wb_data[i*32 +: 32];
            if (wb_valid[i] && (wb_preg[i*PW +: PW] == iss_src2_preg))
                op2 = wb_data[i*32 +: 32];
        end
    end

    // Next-state and storage write enables; flush overrides accept and drain
    always_comb begin
        state_next = state;
        load_h     = 1'b0;
        load_s     = 1'b0;
        move_s     = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        load_h     = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !drain) begin
                        state_next = TWO;
                        load_s     = 1'b1;
                    end else if (accept && drain) begin
                        load_h     = 1'b1;
                    end else if (drain) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_next = ONE;
                        move_s     = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // State register; iss_ready is registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != TWO);
        end
    end

    // Head/skid payload registers; operands are frozen at accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_uop <= '0;
            h_v1  <= '0;
            h_v2  <= '0;
            s_uop <= '0;
            s_v1  <= '0;
            s_v2  <= '0;
        end else begin
            if (load_h) begin
                h_uop <= iss_uop;
                h_v1  <= op1;
                h_v2  <= op2;
            end else if (move_s) begin
                h_uop <= s_uop;
                h_v1  <= s_v1;
                h_v2  <= s_v2;
            end
            if (load_s) begin
                s_uop <= iss_uop;
                s_v1  <= op1;
                s_v2  <= op2;
            end
        end
    end

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed scenarios followed by random traffic,
// all checked against a queue-based model of the stage.
module tb_reg_read_stage;

    localparam int NUM_PREGS = 64;
    localparam int NUM_WB    = 2;
    localparam int UOP_W     = 64;
    localparam int PW        = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 iss_valid;
    logic                 iss_ready;
    logic [PW-1:0]        iss_src1_preg, iss_src2_preg;
    logic [UOP_W-1:0]     iss_uop;
    logic [PW-1:0]        prf_src1_reg, prf_src2_reg;
    logic [31:0]          prf_src1_val, prf_src2_val;
    logic [NUM_WB-1:0]    wb_valid;
    logic [NUM_WB*PW-1:0] wb_preg;
    logic [NUM_WB*32-1:0] wb_data;
    logic                 ex_valid;
    logic                 ex_ready;
    logic [UOP_W-1:0]     ex_uop;
    logic [31:0]          ex_src1_val, ex_src2_val;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [63:0] uop;
        logic [31:0] a;
        logic [31:0] b;
    } ent_t;

    ent_t q[$];

    reg_read_stage #(
        .NUM_PREGS(NUM_PREGS),
        .NUM_WB   (NUM_WB),
        .UOP_W    (UOP_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_src1_preg(iss_src1_preg),
        .iss_src2_preg(iss_src2_preg),
        .iss_uop      (iss_uop),
        .prf_src1_reg (prf_src1_reg),
        .prf_src2_reg (prf_src2_reg),
        .prf_src1_val (prf_src1_val),
        .prf_src2_val (prf_src2_val),
        .wb_valid     (wb_valid),
        .wb_preg      (wb_preg),
        .wb_data      (wb_data),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_uop       (ex_uop),
        .ex_src1_val  (ex_src1_val),
        .ex_src2_val  (ex_src2_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Operand value the stage should capture: last matching writeback wins
    function automatic logic [31:0] pick(input logic [PW-1:0] src, input logic [31:0] prf);
        logic [31:0] r;
        r = prf;
        for (int i = 0; i < NUM_WB; i++)
            if (wb_valid[i] && wb_preg[i*PW +: PW] == src)
                r = wb_data[i*32 +: 32];
        return r;
    endfunction

    // One clock: check outputs at negedge, then advance the model past posedge
    task automatic cycle();
        ent_t e;
        logic acc, drn, fl;
        @(negedge clk);
        chk("iss_ready", 64'(iss_ready), 64'(q.size() < 2));
        chk("ex_valid",  64'(ex_valid),  64'(q.size() > 0));
        chk("prf_src1_reg", 64'(prf_src1_reg), 64'(iss_src1_preg));
        chk("prf_src2_reg", 64'(prf_src2_reg), 64'(iss_src2_preg));
        if (q.size() > 0) begin
            chk("ex_uop", ex_uop, q[0].uop);
            chk("ex_src1_val", 64'(ex_src1_val), 64'(q[0].a));
            chk("ex_src2_val", 64'(ex_src2_val), 64'(q[0].b));
        end
        fl  = flush;
        drn = (q.size() > 0) && ex_ready;
        acc = iss_valid && (q.size() < 2);
        e.uop = iss_uop;
        e.a   = pick(iss_src1_preg, prf_src1_val);
        e.b   = pick(iss_src2_preg, prf_src2_val);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic offer(input logic [PW-1:0] s1, input logic [PW-1:0] s2,
                         input logic [31:0] p1, input logic [31:0] p2);
        iss_valid     = 1'b1;
        iss_src1_preg = s1;
        iss_src2_preg = s2;
        prf_src1_val  = p1;
        prf_src2_val  = p2;
        iss_uop       = {$urandom, $urandom};
    endtask

    task automatic quiet();
        iss_valid = 1'b0;
        wb_valid  = '0;
        flush     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; iss_valid = 1'b0; ex_ready = 1'b0;
        iss_src1_preg = '0; iss_src2_preg = '0; iss_uop = '0;
        prf_src1_val = '0; prf_src2_val = '0;
        wb_valid = '0; wb_preg = '0; wb_data = '0;
        #12 rst = 1'b0;

        // Reset state
        chk("rst_ex_valid", 64'(ex_valid), 64'(0));
        chk("rst_iss_ready", 64'(iss_ready), 64'(1));
        chk("rst_ex_uop", ex_uop, 64'(0));
        cycle();

        // Single uop, no bypass
        ex_ready = 1'b1;
        offer(6'd5, 6'd9, 32'h11, 32'h22);
        cycle();
        quiet();
        chk("t1_src1", 64'(ex_src1_val), 64'h11);
        chk("t1_src2", 64'(ex_src2_val), 64'h22);
        chk("t1_ready", 64'(iss_ready), 64'(1));
        cycle();

        // Bypass from port 0, then from both ports (port 1 wins)
        offer(6'd7, 6'd1, 32'h0, 32'h0);
        wb_valid = 2'b01; wb_preg = {6'd0, 6'd7}; wb_data = {32'h0, 32'hDEAD};
        cycle();
        chk("t2_bypass0", 64'(ex_src1_val), 64'hDEAD);
        offer(6'd7, 6'd1, 32'h0, 32'h0);
        wb_valid = 2'b11; wb_preg = {6'd7, 6'd7}; wb_data = {32'hB, 32'hA};
        cycle();
        quiet();
        chk("t2_bypass1", 64'(ex_src1_val), 64'hB);
        cycle();

        // Backpressure: A, B held; C offered while full
        ex_ready = 1'b0;
        offer(6'd2, 6'd3, 32'hA1, 32'hA2);
        cycle();
        offer(6'd4, 6'd5, 32'hB1, 32'hB2);
        cycle();
        chk("t3_full_ready", 64'(iss_ready), 64'(0));
        chk("t3_head_a", 64'(ex_src1_val), 64'hA1);
        offer(6'd6, 6'd7, 32'hC1, 32'hC2);
        cycle();
        quiet();
        ex_ready = 1'b1;
        cycle();
        chk("t3_head_b", 64'(ex_src1_val), 64'hB1);
        cycle();
        chk("t3_ready_back", 64'(iss_ready), 64'(1));
        cycle();

        // Frozen operands under later writeback
        ex_ready = 1'b0;
        offer(6'd3, 6'd8, 32'h77, 32'h88);
        cycle();
        quiet();
        wb_valid = 2'b01; wb_preg = {6'd0, 6'd3}; wb_data = {32'h0, 32'h55};
        cycle();
        cycle();
        chk("t4_frozen", 64'(ex_src1_val), 64'h77);
        quiet();
        ex_ready = 1'b1;
        cycle();

        // Flush while full with an offer pending
        ex_ready = 1'b0;
        offer(6'd1, 6'd2, 32'h1, 32'h2);
        cycle();
        offer(6'd3, 6'd4, 32'h3, 32'h4);
        cycle();
        offer(6'd5, 6'd6, 32'h5, 32'h6);
        flush = 1'b1;
        cycle();
        quiet();
        chk("t5_ex_valid", 64'(ex_valid), 64'(0));
        chk("t5_ready", 64'(iss_ready), 64'(1));
        cycle();

        // Async reset while full
        offer(6'd1, 6'd2, 32'h1, 32'h2);
        cycle();
        offer(6'd3, 6'd4, 32'h3, 32'h4);
        cycle();
        quiet();
        #2 rst = 1'b1;
        #1;
        chk("t6_ex_valid", 64'(ex_valid), 64'(0));
        chk("t6_ex_uop", ex_uop, 64'(0));
        chk("t6_src1", 64'(ex_src1_val), 64'(0));
        chk("t6_src2", 64'(ex_src2_val), 64'(0));
        q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        chk("t6_ready", 64'(iss_ready), 64'(1));
        cycle();

        // Random traffic with small preg range to exercise bypass hits
        for (int n = 0; n < 400; n++) begin
            iss_valid     = ($urandom_range(0, 3) != 0);
            ex_ready      = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 24) == 0);
            iss_src1_preg = PW'($urandom_range(0, 7));
            iss_src2_preg = PW'($urandom_range(0, 7));
            iss_uop       = {$urandom, $urandom};
            prf_src1_val  = $urandom;
            prf_src2_val  = $urandom;
            wb_valid      = NUM_WB'($urandom_range(0, 3));
            wb_preg       = {PW'($urandom_range(0, 7)), PW'($urandom_range(0, 7))};
            wb_data       = {$urandom, $urandom};
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
